// File: rtl/fpu_scoreboard_if.sv
// Issue-stage interface of the FP register scoreboard: instruction fields and
// flush in, stall request and per-register pending-write map out.
interface fpu_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int IDX_W = 5,
    parameter int LAT_W = 3
);
    logic             issue_valid;
    logic             issue_regwrite;
    logic [IDX_W-1:0] issue_rd;
    logic [LAT_W-1:0] issue_lat;
    logic [IDX_W-1:0] rs1i;
    logic [IDX_W-1:0] rs2i;
    logic [IDX_W-1:0] rs3i;
    logic             use_rs1;
    logic             use_rs2;
    logic             use_rs3;
    logic             flush;
    logic             hazard;
    logic [NREG-1:0]  busy;

    modport master (
        output issue_valid, issue_regwrite, issue_rd, issue_lat,
        output rs1i, rs2i, rs3i, use_rs1, use_rs2, use_rs3, flush,
        input  hazard, busy
    );

    modport slave (
        input  issue_valid, issue_regwrite, issue_rd, issue_lat,
        input  rs1i, rs2i, rs3i, use_rs1, use_rs2, use_rs3, flush,
        output hazard, busy
    );
endinterface

// File: rtl/fpu_scoreboard.sv
// FP register scoreboard: per-register countdown of cycles until a pending write
// lands; stalls RAW/WAW hazards. Define FPU_SB_FWD_EN to let readers go when cnt = 1.
module fpu_scoreboard #(
    parameter int NREG    = 32,
    parameter int IDX_W   = 5,
    parameter int MAX_LAT = 7,
    parameter int LAT_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    fpu_scoreboard_if.slave   sb
);

    localparam int unsigned      NREG_U = NREG;
    localparam logic [LAT_W-1:0] MAX_L  = LAT_W'(MAX_LAT);
`ifdef FPU_SB_FWD_EN
    localparam logic [LAT_W-1:0] THRESH = LAT_W'(1);
`else
    localparam logic [LAT_W-1:0] THRESH = '0;
`endif

    logic [LAT_W-1:0] cnt [NREG];

    logic [LAT_W-1:0] lat_sat;
    logic [LAT_W-1:0] c1, c2, c3, crd;
    logic             raw1, raw2, raw3, waw;
    logic             accept;

    // Lookups match only indices below NREG, so out-of-range indices read as idle.
    always_comb begin
        c1  = '0;
        c2  = '0;
        c3  = '0;
        crd = '0;
        for (int unsigned r = 0; r < NREG_U; r++) begin
            if (sb.rs1i == IDX_W'(r))     c1  = cnt[r];
            if (sb.rs2i == IDX_W'(r))     c2  = cnt[r];
            if (sb.rs3i == IDX_W'(r))     c3  = cnt[r];
            if (sb.issue_rd == IDX_W'(r)) crd = cnt[r];
        end
    end

    always_comb begin
        lat_sat   = (sb.issue_lat > MAX_L) ? MAX_L : sb.issue_lat;
        raw1      = sb.use_rs1 && (c1 > THRESH);
        raw2      = sb.use_rs2 && (c2 > THRESH);
        raw3      = sb.use_rs3 && (c3 > THRESH);
        waw       = sb.issue_regwrite && (lat_sat != '0) && (crd >= lat_sat);
        sb.hazard = sb.issue_valid && (raw1 || raw2 || raw3 || waw);
        accept    = sb.issue_valid && sb.issue_regwrite && !sb.hazard &&
                    (lat_sat != '0) && !sb.flush;
    end

    always_ff @(posedge clk) begin
        if (rst || sb.flush) begin
            for (int unsigned r = 0; r < NREG_U; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREG_U; r++) begin
                if (accept && (sb.issue_rd == IDX_W'(r))) begin
                    cnt[r] <= lat_sat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        sb.busy = '0;
        for (int unsigned r = 0; r < NREG_U; r++) begin
            sb.busy[r] = (cnt[r] != '0);
        end
    end

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Self-checking bench for fpu_scoreboard: directed scenarios plus random traffic
// against a completion-time reference model.
module tb_fpu_scoreboard;

    localparam int NREG    = 32;
    localparam int IDX_W   = 5;
    localparam int LAT_W   = 3;
    localparam int MAX_LAT = 7;
`ifdef FPU_SB_FWD_EN
    localparam int T = 1;
`else
    localparam int T = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_scoreboard_if #(.NREG(NREG), .IDX_W(IDX_W), .LAT_W(LAT_W)) sb ();
    fpu_scoreboard_if #(.NREG(NREG), .IDX_W(IDX_W), .LAT_W(LAT_W)) sb4 ();

    fpu_scoreboard #(.NREG(NREG), .IDX_W(IDX_W), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    fpu_scoreboard #(.NREG(NREG), .IDX_W(IDX_W), .MAX_LAT(4), .LAT_W(LAT_W)) dut4 (
        .clk (clk),
        .rst (rst),
        .sb  (sb4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: each register remembers the cycle its pending write lands.
    int cyc = 0;
    int done_at [NREG];

    function automatic int rem(input int r);
        return (done_at[r] > cyc) ? done_at[r] - cyc : 0;
    endfunction

    function automatic int sat(input int l);
        return (l > MAX_LAT) ? MAX_LAT : l;
    endfunction

    function automatic bit exp_hazard();
        bit h = 1'b0;
        if (!sb.issue_valid) return 1'b0;
        if (sb.use_rs1 && rem(int'(sb.rs1i)) > T) h = 1'b1;
        if (sb.use_rs2 && rem(int'(sb.rs2i)) > T) h = 1'b1;
        if (sb.use_rs3 && rem(int'(sb.rs3i)) > T) h = 1'b1;
        if (sb.issue_regwrite && sb.issue_lat != 0 &&
            rem(int'(sb.issue_rd)) >= sat(int'(sb.issue_lat))) h = 1'b1;
        return h;
    endfunction

    function automatic logic [NREG-1:0] exp_busy();
        logic [NREG-1:0] v = '0;
        for (int r = 0; r < NREG; r++) v[r] = (rem(r) != 0);
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst || sb.flush) begin
            for (int r = 0; r < NREG; r++) done_at[r] <= 0;
        end else if (sb.issue_valid && sb.issue_regwrite && sb.issue_lat != 0 && !exp_hazard()) begin
            done_at[sb.issue_rd] <= cyc + 1 + sat(int'(sb.issue_lat));
        end
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit wr, input int rd, input int lat,
                         input bit u1, input bit u2, input bit u3,
                         input int r1, input int r2, input int r3, input bit fl);
        sb.issue_valid    = v;
        sb.issue_regwrite = wr;
        sb.issue_rd       = IDX_W'(rd);
        sb.issue_lat      = LAT_W'(lat);
        sb.use_rs1        = u1;
        sb.use_rs2        = u2;
        sb.use_rs3        = u3;
        sb.rs1i           = IDX_W'(r1);
        sb.rs2i           = IDX_W'(r2);
        sb.rs3i           = IDX_W'(r3);
        sb.flush          = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drive4(input bit v, input int rd, input int lat);
        sb4.issue_valid    = v;
        sb4.issue_regwrite = v;
        sb4.issue_rd       = IDX_W'(rd);
        sb4.issue_lat      = LAT_W'(lat);
        sb4.use_rs1        = 1'b0;
        sb4.use_rs2        = 1'b0;
        sb4.use_rs3        = 1'b0;
        sb4.rs1i           = '0;
        sb4.rs2i           = '0;
        sb4.rs3i           = '0;
        sb4.flush          = 1'b0;
    endtask

    task automatic flush_all();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (sb.busy !== '0) begin
            errors++;
            $display("FAIL reset_busy busy=%h expected=%h", sb.busy, {NREG{1'b0}});
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            drive($urandom % 2, 0, $urandom % 32, $urandom % 8, $urandom % 2, $urandom % 2,
                  $urandom % 2, $urandom % 32, $urandom % 32, $urandom % 32, 0);
            @(negedge clk);
            checks++;
            if (sb.hazard !== 1'b0 || sb.busy !== '0) begin
                errors++;
                $display("FAIL post_reset_idle hazard=%b busy=%h expected hazard=0 busy=0",
                         sb.hazard, sb.busy);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_raw_latency();
        int hc;
        hc = (T == 1) ? 3 : 4;
        flush_all();
        drive(1, 1, 3, 4, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (sb.hazard !== 1'b0) begin
            errors++;
            $display("FAIL raw_issue hazard=%b expected=0", sb.hazard);
        end
        tick();
        drive(1, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (sb.busy[3] !== (k < 4)) begin
                errors++;
                $display("FAIL raw_busy3 k=%0d busy3=%b expected=%b", k, sb.busy[3], (k < 4));
            end
            checks++;
            if (sb.hazard !== (k < hc)) begin
                errors++;
                $display("FAIL raw_hazard k=%0d hazard=%b expected=%b", k, sb.hazard, (k < hc));
            end
            tick();
        end
        idle();
    endtask

    task automatic test_waw();
        int n;
        flush_all();
        drive(1, 1, 5, 6, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        drive(1, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (sb.hazard !== 1'b1) begin
            errors++;
            $display("FAIL waw_short hazard=%b expected=1", sb.hazard);
        end
        #1;
        drive(1, 1, 5, 6, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (sb.hazard !== 1'b0) begin
            errors++;
            $display("FAIL waw_longer hazard=%b expected=0", sb.hazard);
        end
        tick();
        idle();
        n = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (sb.busy[5] === 1'b1) n++;
            tick();
        end
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL waw_reload busy5_cycles=%0d expected=6", n);
        end
    endtask

    task automatic test_fused();
        flush_all();
        drive(1, 1, 7, 7, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 7, 7, 7, 0);
        @(negedge clk);
        checks++;
        if (sb.hazard !== 1'b1) begin
            errors++;
            $display("FAIL fused_rs3 hazard=%b expected=1", sb.hazard);
        end
        #1;
        drive(1, 0, 0, 0, 0, 0, 0, 7, 7, 7, 0);
        #1;
        checks++;
        if (sb.hazard !== 1'b0) begin
            errors++;
            $display("FAIL fused_unused hazard=%b expected=0", sb.hazard);
        end
        idle();
    endtask

    task automatic test_flush();
        flush_all();
        drive(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 2, 7, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 9, 7, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 4, 3, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checks++;
        if (sb.busy !== 32'h0000_0206) begin
            errors++;
            $display("FAIL flush_pre busy=%h expected=00000206", sb.busy);
        end
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (sb.busy !== '0) begin
                errors++;
                $display("FAIL flush_clear k=%0d busy=%h expected=0", k, sb.busy);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        flush_all();
        drive(1, 1, 2, 5, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        tick();
        rst = 1'b1;
        drive(1, 1, 6, 5, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (sb.busy !== 32'h0000_0004) begin
            errors++;
            $display("FAIL rstmid_pre busy=%h expected=00000004", sb.busy);
        end
        tick();
        rst = 1'b0;
        idle();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (sb.busy !== '0) begin
                errors++;
                $display("FAIL rstmid_clear k=%0d busy=%h expected=0", k, sb.busy);
            end
            tick();
        end
        drive(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (sb.busy !== '0) begin
            errors++;
            $display("FAIL lat0_noload busy=%h expected=0", sb.busy);
        end
        tick();
        drive(1, 1, 10, 3, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 10, 0, 1, 0, 0, 11, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (sb.hazard !== 1'b0) begin
            errors++;
            $display("FAIL lat0_nowaw hazard=%b expected=0", sb.hazard);
        end
        #1;
        drive(1, 1, 10, 0, 1, 0, 0, 10, 0, 0, 0);
        #1;
        checks++;
        if (sb.hazard !== 1'b1) begin
            errors++;
            $display("FAIL lat0_raw hazard=%b expected=1", sb.hazard);
        end
        tick();
        idle();
    endtask

    task automatic test_saturation();
        int n;
        drive4(1, 12, 7);
        @(negedge clk);
        checks++;
        if (sb4.hazard !== 1'b0) begin
            errors++;
            $display("FAIL sat_issue hazard=%b expected=0", sb4.hazard);
        end
        tick();
        n = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (sb4.hazard !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_waw hazard=%b expected=1", sb4.hazard);
                end
                #1;
                drive4(0, 0, 0);
            end
            if (sb4.busy[12] === 1'b1) n++;
            tick();
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL sat_busy_cycles cycles=%0d expected=4", n);
        end
    endtask

    task automatic test_random();
        logic [NREG-1:0] eb;
        bit eh;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom % 64) == 0;
            drive(($urandom % 4) != 0, $urandom % 2, $urandom % 8, $urandom % 8,
                  $urandom % 2, $urandom % 2, $urandom % 2,
                  $urandom % 8, $urandom % 8, $urandom % 8, ($urandom % 32) == 0);
            @(negedge clk);
            eh = exp_hazard();
            eb = exp_busy();
            checks++;
            if (sb.hazard !== eh) begin
                errors++;
                $display("FAIL rand_hazard i=%0d hazard=%b expected=%b", i, sb.hazard, eh);
            end
            checks++;
            if (sb.busy !== eb) begin
                errors++;
                $display("FAIL rand_busy i=%0d busy=%h expected=%h", i, sb.busy, eb);
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        drive4(0, 0, 0);
        test_reset();
        test_raw_latency();
        test_waw();
        test_fused();
        test_flush();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fpu_scoreboard.md
FPU_SCOREBOARD -- requirements
Module: fpu_scoreboard

Interface
- REQ-001 Parameter NREG, 32, number of FP architectural registers.
- REQ-002 Parameter IDX_W, 5, register index width; SHALL satisfy 2^IDX_W >= NREG.
- REQ-003 Parameter MAX_LAT, 7, longest FPU operation latency in cycles; SHALL be >= 1.
- REQ-004 Parameter LAT_W, 3, latency/counter width; SHALL hold MAX_LAT.
- REQ-005 Port clk, input, 1, single clock; all state updates on rising edge.
- REQ-006 Port rst, input, 1, synchronous active-high reset.
- REQ-007 Port issue_valid, input, 1, instruction present at issue stage.
- REQ-008 Port issue_regwrite, input, 1, instruction writes an FP register.
- REQ-009 Port issue_rd, input, IDX_W, destination index.
- REQ-010 Port issue_lat, input, LAT_W, result latency (1..MAX_LAT); 0 means untracked.
- REQ-011 Ports rs1i/rs2i/rs3i, input, IDX_W each, source indices (rs3 for fused multiply-add).
- REQ-012 Ports use_rs1/use_rs2/use_rs3, input, 1 each, source actually read.
- REQ-013 Port flush, input, 1, pipeline flush; drops all in-flight results.
- REQ-014 Port hazard, output, 1, stall request for the issue stage (combinational).
- REQ-015 Port busy, output, NREG, bit r set when cnt[r] != 0 (registered state).

Function
- REQ-016 The block SHALL hold one LAT_W-bit counter cnt[r] per register; 0 = no pending write.
- REQ-017 raw_k SHALL be use_rsk & (cnt[rsk] > T), k = 1..3; T defined in Configuration.
- REQ-018 waw SHALL be issue_regwrite & (issue_lat != 0) & (cnt[issue_rd] >= issue_lat) — a new write must not complete at or before an older one.
- REQ-019 hazard SHALL be issue_valid & (raw1 | raw2 | raw3 | waw); no dependence on flush or rst.
- REQ-020 Accept SHALL be issue_valid & issue_regwrite & ~hazard & (issue_lat != 0) & ~flush.
- REQ-021 Every cycle, each nonzero cnt[r] SHALL decrement by 1; zero counters hold.
- REQ-022 On accept, cnt[issue_rd] SHALL load issue_lat, overriding the decrement for that entry.
- REQ-023 issue_lat > MAX_LAT SHALL be saturated to MAX_LAT before loading or comparing.
- REQ-024 flush SHALL clear all counters next cycle; flush with a simultaneous issue: flush wins, nothing loaded.
- REQ-025 Source equal to issue_rd of the same instruction SHALL compare against pre-load cnt (no self-hazard).
- REQ-026 Index >= NREG SHALL be treated as cnt = 0 (never hazards, never loaded).

Reset
- REQ-027 rst SHALL clear all cnt[r] to 0 on the next clk edge, overriding accept, decrement and flush.
- REQ-028 After reset, busy SHALL be all-zero and hazard SHALL be 0 for any stimulus until an accept occurs.
- REQ-029 Reset asserted mid-operation SHALL discard all pending entries; no counter resumes afterward.

Configuration
- REQ-030 Macro FPU_SB_FWD_EN: when defined, T = 1 (result forwarded from writeback in its final cycle, so cnt = 1 does not stall).
- REQ-031 Without FPU_SB_FWD_EN, T = 0 (any pending write stalls readers until the counter reaches 0).
- REQ-032 waw and busy SHALL be identical in both configurations.

Verification
- REQ-033 Reset, then issue rd=3 lat=4; next cycle read rs1=3 -> hazard=1; busy[3]=1 for 4 cycles; hazard clears after 3 cycles with FWD_EN, after 4 without.
- REQ-034 Issue rd=5 lat=6; one cycle later issue rd=5 lat=2 -> hazard=1 (waw, cnt 5 >= 2); with lat=6 (cnt 5 < 6) -> accepted, cnt[5]=6.
- REQ-035 Pending rd=7 cnt=5; fused op with use_rs3=1, rs3i=7, use_rs1=use_rs2=0 -> hazard=1; same op with use_rs3=0 -> hazard=0.
- REQ-036 Load rd=1, 2, 9 with lat 7; assert flush together with issue rd=4 lat=3 -> busy=0 next cycle, cnt[4]=0.
- REQ-037 rst with rd=2 pending cnt=3 and a simultaneous accept -> busy=0 next cycle; issue_lat=0 instruction -> never loads, hazard only from RAW.
- REQ-038 issue_lat=7 with MAX_LAT=4 -> cnt loads 4; busy clears after exactly 4 cycles.
